// File: rtl/det4_seq_ctrl_if.sv
// det4_seq_ctrl_if: host write/start port and result port
// of the sequential 4x4 determinant controller.
interface det4_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 8
);
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  result;
  logic              ovf;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, result, ovf
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/det4_seq_ctrl.sv
// det4_seq_ctrl: 4x4 determinant by row-0 Laplace expansion,
// one shared multiplier. Option macro: DET_SAT_EN (saturate result).
module det4_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 8
) (
  input logic           clk,
  input logic           rst_n,
  det4_seq_ctrl_if.slave bus
);
  localparam int T2_W  = 2*DATA_W + 1;
  localparam int MIN_W = 3*DATA_W + 3;
  localparam int ACC_W = 4*DATA_W + 5;
  localparam int P_W   = ACC_W + DATA_W;

  typedef enum logic [2:0] {
    IDLE, M2A, M2B, M3, M4, FIN
  } state_t;

  state_t                    state_q;
  logic [1:0]                j_q, k_q;
  logic signed [DATA_W-1:0]  mat_q [16];
  logic signed [T2_W-1:0]    t2_q;
  logic signed [MIN_W-1:0]   minor_q;
  logic signed [ACC_W-1:0]   det_q;
  logic                      busy_q, done_q, ovf_q;
  logic [RES_W-1:0]          result_q;

  logic [1:0]                mc, cx, cy;
  logic                      found;
  logic signed [ACC_W-1:0]   op_a;
  logic signed [DATA_W-1:0]  op_b;
  logic signed [P_W-1:0]     prod;
  logic signed [MIN_W-1:0]   minor_d;
  logic signed [ACC_W-1:0]   det_d;
  logic                      ovf_d;
  logic [RES_W-1:0]          res_d;

  // Row-1 column of the minor, and the two 2x2 columns left over
  always_comb begin
    mc    = (k_q < j_q) ? k_q : k_q + 2'd1;
    cx    = '0;
    cy    = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i[1:0] != j_q && i[1:0] != mc) begin
        if (!found) begin
          cx    = i[1:0];
          found = 1'b1;
        end else begin
          cy    = i[1:0];
        end
      end
    end
  end

  // Operand select for the single shared multiplier
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      M2A: begin
        op_a = ACC_W'(mat_q[{2'd3, cy}]);
        op_b = mat_q[{2'd2, cx}];
      end
      M2B: begin
        op_a = ACC_W'(mat_q[{2'd3, cx}]);
        op_b = mat_q[{2'd2, cy}];
      end
      M3: begin
        op_a = ACC_W'(t2_q);
        op_b = mat_q[{2'd1, mc}];
      end
      M4: begin
        op_a = ACC_W'(minor_q);
        op_b = mat_q[{2'd0, j_q}];
      end
      default: ;
    endcase
  end

  // Signed product and alternating-sign accumulations
  always_comb begin
    prod    = op_a * op_b;
    minor_d = k_q[0] ? minor_q - $signed(prod[MIN_W-1:0])
                     : minor_q + $signed(prod[MIN_W-1:0]);
    det_d   = j_q[0] ? det_q - $signed(prod[ACC_W-1:0])
                     : det_q + $signed(prod[ACC_W-1:0]);
    ovf_d   = ~((&det_d[ACC_W-1:RES_W-1]) |
                ~(|det_d[ACC_W-1:RES_W-1]));
`ifdef DET_SAT_EN
    if (ovf_d)
      res_d = det_d[ACC_W-1] ? {1'b1, {(RES_W-1){1'b0}}}
                             : {1'b0, {(RES_W-1){1'b1}}};
    else
      res_d = det_d[RES_W-1:0];
`else
    res_d   = det_d[RES_W-1:0];
`endif
  end

  // Sequencer FSM with matrix store and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      j_q      <= '0;
      k_q      <= '0;
      t2_q     <= '0;
      minor_q  <= '0;
      det_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < 16; i++) mat_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.wr_en)
            mat_q[bus.wr_addr] <= $signed(bus.wr_data);
          if (bus.start) begin
            state_q <= M2A;
            j_q     <= '0;
            k_q     <= '0;
            minor_q <= '0;
            det_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        M2A: begin
          t2_q    <= prod[T2_W-1:0];
          state_q <= M2B;
        end
        M2B: begin
          t2_q    <= t2_q - $signed(prod[T2_W-1:0]);
          state_q <= M3;
        end
        M3: begin
          minor_q <= minor_d;
          if (k_q == 2'd2) begin
            k_q     <= '0;
            state_q <= M4;
          end else begin
            k_q     <= k_q + 2'd1;
            state_q <= M2A;
          end
        end
        M4: begin
          det_q   <= det_d;
          minor_q <= '0;
          if (j_q == 2'd3) begin
            result_q <= res_d;
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
            state_q  <= FIN;
          end else begin
            j_q     <= j_q + 2'd1;
            state_q <= M2A;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
endmodule
